// File: rtl/fetch_redirect_ctrl_pkg.sv
// rtl/fetch_redirect_ctrl_pkg.sv - shared widths, redirect source/state enums and PC helper
package fetch_redirect_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] BOOT_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_PRED = 2'd1,
        REDIR_MISP = 2'd2,
        REDIR_EXC  = 2'd3
    } redir_src_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } redir_state_e;

    // Sequential successor of an instruction; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] fallthrough_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(ILEN / 8);
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - redirect request/response bundle between backend, predictor and fetch
interface fetch_redirect_ctrl_if;
    import fetch_redirect_ctrl_pkg::*;

    logic            exc_valid_i;
    logic [XLEN-1:0] exc_vector_i;
    logic            res_valid_i;
    logic            res_mispredict_i;
    logic            res_taken_i;
    logic [XLEN-1:0] res_target_i;
    logic [XLEN-1:0] res_pc_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] pred_target_i;
    logic            fetch_ready_i;
    logic            redir_valid_o;
    logic [XLEN-1:0] redir_target_o;
    redir_src_e      redir_src_o;
    logic            pc_en_o;
    logic            flush_o;

    modport master (
        output exc_valid_i, exc_vector_i, res_valid_i, res_mispredict_i, res_taken_i,
               res_target_i, res_pc_i, pred_taken_i, pred_target_i, fetch_ready_i,
        input  redir_valid_o, redir_target_o, redir_src_o, pc_en_o, flush_o
    );

    modport slave (
        input  exc_valid_i, exc_vector_i, res_valid_i, res_mispredict_i, res_taken_i,
               res_target_i, res_pc_i, pred_taken_i, pred_target_i, fetch_ready_i,
        output redir_valid_o, redir_target_o, redir_src_o, pc_en_o, flush_o
    );

endinterface

// File: rtl/redirect_perf_cnt.sv
// rtl/redirect_perf_cnt.sv - saturating event counter for redirect statistics
module redirect_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - redirect source arbiter and RUN/FLUSH/REDIR sequencer
// Optional REDIRECT_STATS_EN adds per-source hard redirect counters.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    fetch_redirect_ctrl_if.slave bus
`ifdef REDIRECT_STATS_EN
    ,
    output logic [31:0]          misp_cnt_o,
    output logic [31:0]          exc_cnt_o
`endif
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    redir_state_e    state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] tgt_q;
    redir_src_e      src_q;

    logic            hard_exc;
    logic            hard_misp;
    logic            hard;
    logic [XLEN-1:0] misp_tgt;
    logic [XLEN-1:0] hard_tgt;
    redir_src_e      hard_src;

    assign hard_exc  = bus.exc_valid_i;
    assign hard_misp = bus.res_valid_i && bus.res_mispredict_i;
    assign hard      = hard_exc || hard_misp;
    assign misp_tgt  = bus.res_taken_i ? bus.res_target_i : fallthrough_pc(bus.res_pc_i);
    assign hard_tgt  = hard_exc ? bus.exc_vector_i : misp_tgt;
    assign hard_src  = hard_exc ? REDIR_EXC : REDIR_MISP;

    // A hard event preempts every state, including a REDIR handshake in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            tgt_q   <= '0;
            src_q   <= REDIR_NONE;
        end else if (hard) begin
            state_q <= ST_FLUSH;
            cnt_q   <= CW'(FLUSH_CYCLES);
            tgt_q   <= hard_tgt;
            src_q   <= hard_src;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_REDIR;
                    end
                end
                ST_REDIR: begin
                    if (bus.fetch_ready_i) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Soft predictions must reach the PC mux in the cycle they arrive, so outputs decode
    // the registered state together with the live predictor and fetch inputs.
    always_comb begin
        bus.redir_valid_o  = 1'b0;
        bus.redir_target_o = '0;
        bus.redir_src_o    = REDIR_NONE;
        bus.pc_en_o        = 1'b0;
        bus.flush_o        = 1'b0;
        if (rst_n_i) begin
            case (state_q)
                ST_FLUSH: begin
                    bus.flush_o = 1'b1;
                end
                ST_REDIR: begin
                    bus.redir_valid_o  = 1'b1;
                    bus.redir_target_o = tgt_q;
                    bus.redir_src_o    = src_q;
                    bus.pc_en_o        = bus.fetch_ready_i;
                end
                default: begin
                    bus.redir_valid_o  = bus.pred_taken_i;
                    bus.redir_target_o = bus.pred_target_i;
                    bus.redir_src_o    = bus.pred_taken_i ? REDIR_PRED : REDIR_NONE;
                    bus.pc_en_o        = bus.fetch_ready_i;
                end
            endcase
        end
    end

`ifdef REDIRECT_STATS_EN
    redirect_perf_cnt #(.WIDTH(32)) u_exc_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (hard_exc),
        .count_o (exc_cnt_o)
    );

    redirect_perf_cnt #(.WIDTH(32)) u_misp_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (hard_misp && !hard_exc),
        .count_o (misp_cnt_o)
    );
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
    import fetch_redirect_ctrl_pkg::*;

    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_redirect_ctrl_if bus ();

`ifdef REDIRECT_STATS_EN
    logic [31:0] misp_cnt;
    logic [31:0] exc_cnt;
`endif

    fetch_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
`ifdef REDIRECT_STATS_EN
        ,
        .misp_cnt_o (misp_cnt),
        .exc_cnt_o  (exc_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: remaining flush cycles, a pending hard target, and per-source tallies.
    int          m_left;
    bit          m_pend;
    logic [31:0] m_tgt;
    logic [1:0]  m_src;
    longint      m_exc;
    longint      m_misp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_pend <= 1'b0;
            m_tgt  <= '0;
            m_src  <= REDIR_NONE;
            m_exc  <= 0;
            m_misp <= 0;
        end else if (bus.exc_valid_i || (bus.res_valid_i && bus.res_mispredict_i)) begin
            m_left <= FC;
            m_pend <= 1'b1;
            if (bus.exc_valid_i) begin
                m_tgt <= bus.exc_vector_i;
                m_src <= REDIR_EXC;
                m_exc <= (m_exc < 64'hFFFF_FFFF) ? m_exc + 1 : m_exc;
            end else begin
                m_tgt  <= bus.res_taken_i ? bus.res_target_i : bus.res_pc_i + 32'(ILEN / 8);
                m_src  <= REDIR_MISP;
                m_misp <= (m_misp < 64'hFFFF_FFFF) ? m_misp + 1 : m_misp;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (m_pend && bus.fetch_ready_i) begin
            m_pend <= 1'b0;
        end
    end

    task automatic idle(input logic ready);
        bus.exc_valid_i      = 1'b0;
        bus.exc_vector_i     = '0;
        bus.res_valid_i      = 1'b0;
        bus.res_mispredict_i = 1'b0;
        bus.res_taken_i      = 1'b0;
        bus.res_target_i     = '0;
        bus.res_pc_i         = '0;
        bus.pred_taken_i     = 1'b0;
        bus.pred_target_i    = '0;
        bus.fetch_ready_i    = ready;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle(1'b1);
        bus.pred_taken_i  = 1'b1;
        bus.pred_target_i = 32'h55;
        bus.exc_valid_i   = 1'b1;
        #1;
        checks++;
        if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b t=%h s=%0d pe=%0b f=%0b want all 0", bus.redir_valid_o,
                     bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o);
        end
        cyc();
        checks++;
        if ({bus.redir_valid_o, bus.pc_en_o, bus.flush_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held got v=%0b pe=%0b f=%0b want 000", bus.redir_valid_o, bus.pc_en_o, bus.flush_o);
        end
`ifdef REDIRECT_STATS_EN
        checks++;
        if ({exc_cnt, misp_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters got exc=%0d misp=%0d want 0 0", exc_cnt, misp_cnt);
        end
`endif
        idle(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_predict();
        bus.pred_taken_i  = 1'b1;
        bus.pred_target_i = 32'h100;
        bus.fetch_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o} !==
            {1'b1, 32'h100, REDIR_PRED, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL predict got v=%0b t=%h s=%0d pe=%0b f=%0b want 1 100 1 1 0", bus.redir_valid_o,
                     bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o);
        end
        bus.pred_taken_i  = 1'b0;
        bus.fetch_ready_i = 1'b0;
        #1;
        checks++;
        if ({bus.redir_valid_o, bus.redir_src_o, bus.pc_en_o} !== {1'b0, REDIR_NONE, 1'b0}) begin
            errors++;
            $display("FAIL predict_not_taken got v=%0b s=%0d pe=%0b want 0 0 0", bus.redir_valid_o,
                     bus.redir_src_o, bus.pc_en_o);
        end
        cyc();
    endtask

    task automatic test_misp_not_taken();
        bus.res_mispredict_i = 1'b1;
        cyc();
        @(negedge clk);
        checks++;
        if (bus.flush_o !== 1'b0) begin
            errors++;
            $display("FAIL misp_without_valid got flush=%0b want 0", bus.flush_o);
        end
        cyc();
        bus.res_valid_i  = 1'b1;
        bus.res_taken_i  = 1'b0;
        bus.res_pc_i     = 32'h2000;
        bus.res_target_i = 32'hdead_0000;
        cyc();
        idle(1'b1);
        bus.pred_taken_i  = 1'b1;
        bus.pred_target_i = 32'h777;
        for (int k = 0; k < FC; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.flush_o, bus.pc_en_o, bus.redir_valid_o} !== 3'b100) begin
                errors++;
                $display("FAIL misp_flush[%0d] got f=%0b pe=%0b v=%0b want 1 0 0", k, bus.flush_o,
                         bus.pc_en_o, bus.redir_valid_o);
            end
            cyc();
        end
        @(negedge clk);
        checks++;
        if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o} !==
            {1'b1, 32'h2004, REDIR_MISP, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL misp_redir got v=%0b t=%h s=%0d pe=%0b f=%0b want 1 2004 2 1 0", bus.redir_valid_o,
                     bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o} !== {1'b1, 32'h777, REDIR_PRED}) begin
            errors++;
            $display("FAIL misp_back_to_run got v=%0b t=%h s=%0d want 1 777 1", bus.redir_valid_o,
                     bus.redir_target_o, bus.redir_src_o);
        end
        cyc();
        idle(1'b0);
    endtask

    task automatic test_tie();
        do_reset();
        bus.exc_valid_i      = 1'b1;
        bus.exc_vector_i     = 32'h80;
        bus.res_valid_i      = 1'b1;
        bus.res_mispredict_i = 1'b1;
        bus.res_taken_i      = 1'b1;
        bus.res_target_i     = 32'h4000;
        cyc();
        idle(1'b0);
        repeat (FC) cyc();
        @(negedge clk);
        checks++;
        if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o} !== {1'b1, 32'h80, REDIR_EXC}) begin
            errors++;
            $display("FAIL tie got v=%0b t=%h s=%0d want 1 80 3", bus.redir_valid_o, bus.redir_target_o,
                     bus.redir_src_o);
        end
`ifdef REDIRECT_STATS_EN
        checks++;
        if ({exc_cnt, misp_cnt} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL tie_counters got exc=%0d misp=%0d want 1 0", exc_cnt, misp_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 5; k++) begin
            bus.pred_taken_i  = 1'($urandom_range(0, 1));
            bus.pred_target_i = $urandom;
            @(negedge clk);
            checks++;
            if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o} !==
                {1'b1, 32'h80, REDIR_EXC, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL backpressure[%0d] got v=%0b t=%h s=%0d pe=%0b f=%0b want 1 80 3 0 0", k,
                         bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o);
            end
            cyc();
        end
        bus.fetch_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.redir_valid_o, bus.pc_en_o} !== 2'b11) begin
            errors++;
            $display("FAIL handshake got v=%0b pe=%0b want 1 1", bus.redir_valid_o, bus.pc_en_o);
        end
        cyc();
        bus.pred_taken_i  = 1'b1;
        bus.pred_target_i = 32'h44;
        @(negedge clk);
        checks++;
        if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o, bus.flush_o} !==
            {1'b1, 32'h44, REDIR_PRED, 1'b0}) begin
            errors++;
            $display("FAIL after_handshake got v=%0b t=%h s=%0d f=%0b want 1 44 1 0", bus.redir_valid_o,
                     bus.redir_target_o, bus.redir_src_o, bus.flush_o);
        end
        cyc();
        idle(1'b0);
    endtask

    task automatic test_re_redirect();
        int n;
        n = 0;
        bus.fetch_ready_i    = 1'b1;
        bus.res_valid_i      = 1'b1;
        bus.res_mispredict_i = 1'b1;
        bus.res_taken_i      = 1'b1;
        bus.res_target_i     = 32'h3000;
        cyc();
        idle(1'b1);
        bus.exc_valid_i  = 1'b1;
        bus.exc_vector_i = 32'h90;
        @(negedge clk);
        if (bus.flush_o) n++;
        cyc();
        idle(1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.flush_o) break;
            n++;
            cyc();
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL re_redirect_flush_len got %0d want 3", n);
        end
        checks++;
        if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o} !== {1'b1, 32'h90, REDIR_EXC}) begin
            errors++;
            $display("FAIL re_redirect_target got v=%0b t=%h s=%0d want 1 90 3", bus.redir_valid_o,
                     bus.redir_target_o, bus.redir_src_o);
        end
        cyc();
        idle(1'b0);
    endtask

    task automatic test_reset_mid_flush();
        bus.exc_valid_i  = 1'b1;
        bus.exc_vector_i = 32'h70;
        cyc();
        idle(1'b1);
        bus.pred_taken_i  = 1'b1;
        bus.pred_target_i = 32'h123;
        @(negedge clk);
        checks++;
        if (bus.flush_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_flush_pre got flush=%0b want 1", bus.flush_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.redir_valid_o, bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o} !== 37'd0) begin
            errors++;
            $display("FAIL mid_flush_reset got v=%0b t=%h s=%0d pe=%0b f=%0b want all 0", bus.redir_valid_o,
                     bus.redir_target_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o);
        end
`ifdef REDIRECT_STATS_EN
        checks++;
        if ({exc_cnt, misp_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL mid_flush_counters got exc=%0d misp=%0d want 0 0", exc_cnt, misp_cnt);
        end
`endif
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.redir_valid_o, bus.redir_src_o, bus.pc_en_o, bus.flush_o} !== {1'b1, REDIR_PRED, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_flush_run got v=%0b s=%0d pe=%0b f=%0b want 1 1 1 0", bus.redir_valid_o,
                     bus.redir_src_o, bus.pc_en_o, bus.flush_o);
        end
        cyc();
        idle(1'b0);
    endtask

    task automatic test_random();
        logic        e_v, e_pe, e_f, chk;
        logic [31:0] e_t;
        logic [1:0]  e_s;
        for (int i = 0; i < 500; i++) begin
            bus.exc_valid_i      = ($urandom_range(0, 11) == 0);
            bus.exc_vector_i     = $urandom;
            bus.res_valid_i      = ($urandom_range(0, 4) == 0);
            bus.res_mispredict_i = 1'($urandom_range(0, 1));
            bus.res_taken_i      = 1'($urandom_range(0, 1));
            bus.res_target_i     = $urandom;
            bus.res_pc_i         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.pred_taken_i     = 1'($urandom_range(0, 1));
            bus.pred_target_i    = $urandom;
            bus.fetch_ready_i    = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            chk = 1'b1;
            e_t = '0;
            e_s = REDIR_NONE;
            if (m_left > 0) begin
                {e_v, e_pe, e_f} = 3'b001;
                chk = 1'b0;
            end else if (m_pend) begin
                {e_v, e_pe, e_f} = {1'b1, bus.fetch_ready_i, 1'b0};
                e_t = m_tgt;
                e_s = m_src;
            end else begin
                {e_v, e_pe, e_f} = {bus.pred_taken_i, bus.fetch_ready_i, 1'b0};
                e_t = bus.pred_target_i;
                e_s = bus.pred_taken_i ? REDIR_PRED : REDIR_NONE;
            end
            checks++;
            if ({bus.redir_valid_o, bus.pc_en_o, bus.flush_o} !== {e_v, e_pe, e_f}) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got v=%0b pe=%0b f=%0b want %0b %0b %0b", i, bus.redir_valid_o,
                         bus.pc_en_o, bus.flush_o, e_v, e_pe, e_f);
            end
            if (chk) begin
                checks++;
                if (bus.redir_src_o !== e_s || (e_v && bus.redir_target_o !== e_t)) begin
                    errors++;
                    $display("FAIL rand_target[%0d] got t=%h s=%0d want %h %0d", i, bus.redir_target_o,
                             bus.redir_src_o, e_t, e_s);
                end
            end
`ifdef REDIRECT_STATS_EN
            checks++;
            if ({exc_cnt, misp_cnt} !== {m_exc[31:0], m_misp[31:0]}) begin
                errors++;
                $display("FAIL rand_counters[%0d] got exc=%0d misp=%0d want %0d %0d", i, exc_cnt, misp_cnt,
                         m_exc, m_misp);
            end
`endif
            cyc();
        end
        idle(1'b0);
    endtask

    initial begin
        test_reset();
        test_predict();
        test_misp_not_taken();
        test_tie();
        test_backpressure();
        test_re_redirect();
        test_reset_mid_flush();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
